// File: rtl/gol_pkg.sv
// Shared constants and grid-geometry helpers for the 8x8 Game of Life block.
// Cell (r,c) lives at bit 63-8r-c, so row 0 is the top byte and column 0 is each byte's MSB.
package gol_pkg;

    localparam int DIM   = 8;
    localparam int CELLS = DIM * DIM;
    localparam int NBRS  = 8;

    localparam logic [CELLS-1:0] GLIDER = 64'h4020_E000_0000_0000;

    // Row/column offsets of the eight neighbours, scanned top-left to bottom-right.
    localparam int signed DR [NBRS] = '{-1, -1, -1,  0, 0,  1, 1, 1};
    localparam int signed DC [NBRS] = '{-1,  0,  1, -1, 1, -1, 0, 1};

    function automatic logic [5:0] cell_idx(int signed r, int signed c);
        return 6'(CELLS - 1 - DIM * r - c);
    endfunction

    // Positions outside the grid read as dead; the edges never wrap around.
    function automatic logic cell_at(logic [CELLS-1:0] g, int signed r, int signed c);
        if (r < 0 || r >= DIM || c < 0 || c >= DIM)
            return 1'b0;
        return g[cell_idx(r, c)];
    endfunction

endpackage

// File: rtl/gol_if.sv
// Per-cell connection: present cell value, its eight neighbours, and the next-generation value.
interface gol_if;

    logic       cur;
    logic [7:0] nbr;
    logic       nxt;

    modport master (output cur, output nbr, input  nxt);
    modport slave  (input  cur, input  nbr, output nxt);

endinterface

// File: rtl/gol_cell.sv
// One Conway B3/S23 cell: popcount of the eight neighbours followed by the birth/survival rule.
module gol_cell
    import gol_pkg::*;
(
    gol_if.slave io
);

    logic [3:0] cnt;

    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < NBRS; i++)
            cnt = cnt + {3'b000, io.nbr[i]};
        io.nxt = (cnt == 4'd3) | (io.cur & (cnt == 4'd2));
    end

endmodule

// File: rtl/gol.sv
// 8x8 Game of Life: 64 cell-rule instances feed a 64-flop generation register loaded with SEED on start.
module gol
    import gol_pkg::*;
#(
    parameter logic [63:0] SEED = GLIDER
)
(
    input  logic        start,
    input  logic        clk,
    output logic [63:0] outGrid
);

    logic [CELLS-1:0] grid_p0;
    logic [CELLS-1:0] nxt_grid;

    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            gol_if cif ();

            for (genvar k = 0; k < NBRS; k++) begin : g_nbr
                assign cif.nbr[k] = cell_at(grid_p0, r + DR[k], c + DC[k]);
            end

            assign cif.cur                = grid_p0[cell_idx(r, c)];
            assign nxt_grid[cell_idx(r, c)] = cif.nxt;

            gol_cell u_cell (
                .io (cif.slave)
            );
        end
    end

    // Stage p0: whole generation advances at once; start overrides evolution.
    always_ff @(posedge clk) begin
        if (start)
            grid_p0 <= SEED;
        else
            grid_p0 <= nxt_grid;
    end

    assign outGrid = grid_p0;

endmodule

// File: tb/tb_gol.sv
// Scoreboarded bench: five seeded gol instances share one start line, plus a standalone cell-rule check.
module tb_gol;

    localparam logic [63:0] GL_SEED  = 64'h4020_E000_0000_0000;
    localparam logic [63:0] BL_V     = 64'h0000_0010_1010_0000;
    localparam logic [63:0] BL_H     = 64'h0000_0000_3800_0000;
    localparam logic [63:0] ED_V     = 64'h0000_0080_8080_0000;
    localparam logic [63:0] ED_1     = 64'h0000_0000_C000_0000;
    localparam logic [63:0] BLOCK    = 64'hC0C0_0000_0000_0000;
    localparam logic [63:0] SINGLE   = 64'h0000_0000_1000_0000;

    localparam logic [63:0] GL [4] = '{64'h00A0_6040_0000_0000,
                                       64'h0020_A060_0000_0000,
                                       64'h0040_3060_0000_0000,
                                       64'h0020_1070_0000_0000};

    // Cell-rule vectors: {cur, nbr, expected next}.
    localparam int NCV = 12;
    localparam logic [9:0] CV [NCV] = '{
        {1'b1, 8'hFF, 1'b0}, {1'b0, 8'h07, 1'b1}, {1'b1, 8'h03, 1'b1},
        {1'b1, 8'h07, 1'b1}, {1'b0, 8'h03, 1'b0}, {1'b1, 8'h01, 1'b0},
        {1'b1, 8'h0F, 1'b0}, {1'b0, 8'hFF, 1'b0}, {1'b0, 8'h00, 1'b0},
        {1'b1, 8'h00, 1'b0}, {1'b0, 8'hE0, 1'b1}, {1'b0, 8'h0F, 1'b0}};

    typedef struct {
        int          step;
        logic [63:0] eg, eb, ee, ek, es;
        logic        ec;
    } exp_t;

    logic        clk = 1'b0;
    logic        start;
    logic [63:0] og, ob, oe, ok, os;

    exp_t q[$];
    int   applied = 0;
    int   miscompares = 0;
    int   step = 0;
    int   gen = 0;

    always #5 clk = ~clk;

    gol #(.SEED(GL_SEED)) u_glider (.start(start), .clk(clk), .outGrid(og));
    gol #(.SEED(BL_V))    u_blink  (.start(start), .clk(clk), .outGrid(ob));
    gol #(.SEED(ED_V))    u_edge   (.start(start), .clk(clk), .outGrid(oe));
    gol #(.SEED(BLOCK))   u_block  (.start(start), .clk(clk), .outGrid(ok));
    gol #(.SEED(SINGLE))  u_single (.start(start), .clk(clk), .outGrid(os));

    gol_if   cif ();
    gol_cell u_cell (.io(cif.slave));

    function automatic logic [63:0] glider_gen(int g);
        if (g == 0)
            return GL_SEED;
        return GL[(g - 1) % 4] >> (9 * ((g - 1) / 4));
    endfunction

    task automatic chk(string name, int st, logic [63:0] act, logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s step %0d: got %h expected %h", name, st, act, exp);
        end
    endtask

    task automatic apply(logic s);
        exp_t e;
        logic [9:0] v;
        @(negedge clk);
        start = s;
        gen   = s ? 0 : gen + 1;
        v     = CV[step % NCV];
        cif.cur = v[9];
        cif.nbr = v[8:1];
        e.step = step;
        e.eg   = glider_gen(gen);
        e.eb   = (gen % 2 == 1) ? BL_H : BL_V;
        e.ee   = (gen == 0) ? ED_V : (gen == 1) ? ED_1 : 64'h0;
        e.ek   = BLOCK;
        e.es   = (gen == 0) ? SINGLE : 64'h0;
        e.ec   = v[0];
        q.push_back(e);
        step++;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("glider", e.step, og, e.eg);
            chk("blinker", e.step, ob, e.eb);
            chk("edge_blinker", e.step, oe, e.ee);
            chk("block", e.step, ok, e.ek);
            chk("single", e.step, os, e.es);
            chk("cell_rule", e.step, {63'd0, cif.nxt}, {63'd0, e.ec});
        end
    end

    initial begin
        start   = 1'b1;
        cif.cur = 1'b0;
        cif.nbr = 8'h00;
        repeat (4)  apply(1'b1);
        repeat (10) apply(1'b0);
        apply(1'b1);
        repeat (5)  apply(1'b0);
        begin
            int budget = 20;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (q.size() > 0) begin
                miscompares++;
                $display("FAIL drain: %0d entries left, expected 0", q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/gol.md
GOL -- requirements
Module: gol

Interface
REQ-001 Parameter SEED, 64-bit, default 64'h4020_E000_0000_0000 (glider in rows 0-2, cols 0-2); pattern loaded on reset.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 start  input  1  reset, synchronous and active-high; loads SEED.
REQ-004 outGrid  output  64  current 8x8 generation, registered.
REQ-005 Positional port order SHALL be start, clk, outGrid.
REQ-006 Cell (r,c), r = row 0..7 top to bottom, c = column 0..7 left to right, SHALL map to outGrid[63-8r-c]; row r occupies outGrid[63-8r -: 8], MSB = column 0.

Function
REQ-007 Grid state SHALL be exactly 64 flops driving outGrid directly, with no combinational path from start to outGrid.
REQ-008 On each rising clk with start=0, next state SHALL be one Conway B3/S23 generation of the current state.
REQ-009 Live cell with 2 or 3 live neighbours SHALL stay live; otherwise it SHALL die.
REQ-010 Dead cell with exactly 3 live neighbours SHALL become live; otherwise it SHALL stay dead.
REQ-011 Neighbours SHALL be the up-to-8 adjacent cells; positions outside the 8x8 grid count as dead (no wrap-around on rows or columns).
REQ-012 All 64 cells SHALL update simultaneously from the previous state (no in-place sequential update).
REQ-013 Latency: one generation per clock; the first edge with start=0 after reset SHALL produce generation 1.
REQ-014 Neighbour count SHALL be 4 bits wide (0..8) with no overflow.
REQ-015 An all-dead grid SHALL remain all-dead; still lifes SHALL stay unchanged indefinitely.

Reset
REQ-016 On any rising clk with start=1, outGrid SHALL become SEED regardless of current state, including mid-evolution.
REQ-017 While start is held high, outGrid SHALL stay at SEED.
REQ-018 outGrid is unspecified before the first start=1 edge; there is no other reset source.

Structure
REQ-019 Shared package gol_pkg SHALL hold: grid dimension constant 8, cell-count constant 64, GLIDER seed constant, and the (r,c)-to-bit-index mapping.
REQ-020 Sub-module gol_cell SHALL take the current cell value and 8 neighbour bits and return the next cell value (popcount plus B3/S23 rule).
REQ-021 Top level SHALL instantiate gol_cell 64 times via generate, tying out-of-grid neighbours to 0, and hold the 64-bit state register.

Verification
REQ-022 Default SEED, start=1 for 4 edges then 0 -> outGrid = 4020_E000_0000_0000 during reset; then 00A0_6040_0000_0000, 0020_A060_0000_0000, 0040_3060_0000_0000, 0020_1070_0000_0000 (glider moves one row down and one column right per 4 generations).
REQ-023 SEED = vertical blinker at col 3, rows 3-5 (0000_0010_1010_0000) -> alternates with horizontal row 4, cols 2-4 (0000_0000_3800_0000) every clock.
REQ-024 SEED = vertical blinker at col 0, rows 3-5 (0000_0080_8080_0000) -> 0000_0000_C000_0000, then 0; no bits set in column 7 (proves no wrap).
REQ-025 SEED = 2x2 block in corner rows 0-1, cols 0-1 (C0C0_0000_0000_0000) -> unchanged for 10 clocks.
REQ-026 Default glider run for 10 generations, then start=1 for 1 edge -> outGrid = SEED on that edge; generation 1 on the next edge after start falls.
REQ-027 SEED = a single live cell -> 0 after one clock and stays 0.
